// File: rtl/axi_bram_read_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// axi_bram_read_arbiter_pkg
// Shared definitions for the two-master BRAM read arbiter:
//   - FSM state encoding (IDLE/ADDR/CAPT/RESP)
//   - AXI response code used on both R channels
//   - clogb2 helper used to derive the byte-offset width of an AXI address
// -----------------------------------------------------------------------------
package axi_bram_read_arbiter_pkg;

    localparam logic [1:0] STATE_IDLE = 2'd0;
    localparam logic [1:0] STATE_ADDR = 2'd1;
    localparam logic [1:0] STATE_CAPT = 2'd2;
    localparam logic [1:0] STATE_RESP = 2'd3;

    typedef enum logic [1:0] {
        IDLE = STATE_IDLE,  // waiting for an arvalid, arbitration active
        ADDR = STATE_ADDR,  // word address presented, BRAM samples at cycle end
        CAPT = STATE_CAPT,  // BRAM data valid, captured into owner's rdata register
        RESP = STATE_RESP   // rvalid to owner until rready
    } state_t;

    localparam logic [1:0] AXI_RESP_OKAY = 2'd0;

    // Number of bits needed to represent value (0 -> 0, 3 -> 2, 4 -> 3).
    function automatic int clogb2(input int value);
        int v;
        int n;
        v = value;
        for (n = 0; v > 0; n++) begin
            v = v >> 1;
        end
        return n;
    endfunction

endpackage

// File: rtl/axi_bram_read_arbiter_rr_arbiter2.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
// Two-requester round-robin arbiter, purely combinational.
//   req[1:0]  request lines
//   last      index of the requester granted most recently
//   en        arbitration enable; gnt is zero when low
//   gnt[1:0]  one-hot grant, or zero when disabled / no request
// When both request, the one that did not win last time is granted.
// -----------------------------------------------------------------------------
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last,
    input  logic       en,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = last ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/axi_bram_read_arbiter.sv
// -----------------------------------------------------------------------------
// axi_bram_read_arbiter
// Shares one BRAM read port between two AXI4-Lite read-only slaves (AR + R).
// One transaction in flight; round-robin between the slaves; read data is
// captured into a per-slave register so R never depends on BRAM output hold.
//
// Ports
//   aclk, areset            clock, synchronous active-high reset
//   s{0,1}_axi_araddr/arvalid/arready   AR channel per slave
//   s{0,1}_axi_rdata/rresp/rvalid/rready R channel per slave (rresp always OKAY)
//   bram_porta_clk/rst      forwarded aclk/areset
//   bram_porta_addr         registered word address
//   bram_porta_rddata       BRAM data, valid one cycle after address sampled
//
// Timing: grant in IDLE cycle N, ADDR at N+1, CAPT at N+2, rvalid from N+3.
// -----------------------------------------------------------------------------
module axi_bram_read_arbiter
    import axi_bram_read_arbiter_pkg::*;
#(
    parameter int AXI_DATA_WIDTH  = 32,
    parameter int AXI_ADDR_WIDTH  = 16,
    parameter int BRAM_DATA_WIDTH = 32,
    parameter int BRAM_ADDR_WIDTH = 10
) (
    input  logic                       aclk,
    input  logic                       areset,

    input  logic [AXI_ADDR_WIDTH-1:0]  s0_axi_araddr,
    input  logic                       s0_axi_arvalid,
    output logic                       s0_axi_arready,
    output logic [AXI_DATA_WIDTH-1:0]  s0_axi_rdata,
    output logic [1:0]                 s0_axi_rresp,
    output logic                       s0_axi_rvalid,
    input  logic                       s0_axi_rready,

    input  logic [AXI_ADDR_WIDTH-1:0]  s1_axi_araddr,
    input  logic                       s1_axi_arvalid,
    output logic                       s1_axi_arready,
    output logic [AXI_DATA_WIDTH-1:0]  s1_axi_rdata,
    output logic [1:0]                 s1_axi_rresp,
    output logic                       s1_axi_rvalid,
    input  logic                       s1_axi_rready,

    output logic                       bram_porta_clk,
    output logic                       bram_porta_rst,
    output logic [BRAM_ADDR_WIDTH-1:0] bram_porta_addr,
    input  logic [BRAM_DATA_WIDTH-1:0] bram_porta_rddata
);

    localparam int ADDR_LSB = clogb2(AXI_DATA_WIDTH / 8 - 1);

    // Slave-indexed views of the two port sets.
    logic [AXI_ADDR_WIDTH-1:0]  araddr_v [2];
    logic [AXI_DATA_WIDTH-1:0]  rdata_v  [2];
    logic [1:0]                 arvalid_v;
    logic [1:0]                 rready_v;
    logic [1:0]                 rvalid_v;
    logic [1:0]                 gnt;

    state_t                     state_reg;
    logic                       owner_reg;
    logic                       last_reg;
    logic [BRAM_ADDR_WIDTH-1:0] addr_reg;

    logic                       win;
    logic [BRAM_ADDR_WIDTH-1:0] win_word;
    logic                       resp_done;

    // Only the word slice of each address is used; the rest is ignored.
    logic                       unused_addr_bits;

    assign araddr_v[0] = s0_axi_araddr;
    assign araddr_v[1] = s1_axi_araddr;
    assign arvalid_v   = {s1_axi_arvalid, s0_axi_arvalid};
    assign rready_v    = {s1_axi_rready,  s0_axi_rready};
    assign unused_addr_bits = ^{s0_axi_araddr, s1_axi_araddr};

    // Arbitration only in IDLE and never during reset, so a handshake is
    // never signalled on a cycle whose transaction would be discarded.
    rr_arbiter2 u_arb (
        .req  (arvalid_v),
        .last (last_reg),
        .en   ((state_reg == IDLE) && !areset),
        .gnt  (gnt)
    );

    assign win       = gnt[1];
    assign win_word  = araddr_v[win][ADDR_LSB +: BRAM_ADDR_WIDTH];
    assign resp_done = rvalid_v[owner_reg] && rready_v[owner_reg];

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_reg <= IDLE;
            owner_reg <= 1'b0;
            last_reg  <= 1'b1;
            addr_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (|gnt) begin
                        addr_reg  <= win_word;
                        owner_reg <= win;
                        last_reg  <= win;
                        state_reg <= ADDR;
                    end
                end
                ADDR:    state_reg <= CAPT;
                CAPT:    state_reg <= RESP;
                RESP: begin
                    if (resp_done) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Per-slave R channel registers. rdata only changes when that slave owns
    // the capture, so a non-owner keeps presenting its previous read data.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic                      rvalid_reg;
            logic [AXI_DATA_WIDTH-1:0] rdata_reg;

            always_ff @(posedge aclk) begin
                if (areset) begin
                    rvalid_reg <= 1'b0;
                    rdata_reg  <= '0;
                end else if ((state_reg == CAPT) && (owner_reg == 1'(gi))) begin
                    rvalid_reg <= 1'b1;
                    rdata_reg  <= bram_porta_rddata;
                end else if (rvalid_reg && rready_v[gi]) begin
                    rvalid_reg <= 1'b0;
                end
            end

            assign rvalid_v[gi] = rvalid_reg;
            assign rdata_v[gi]  = rdata_reg;
        end
    endgenerate

    assign s0_axi_arready = gnt[0];
    assign s1_axi_arready = gnt[1];
    assign s0_axi_rvalid  = rvalid_v[0];
    assign s1_axi_rvalid  = rvalid_v[1];
    assign s0_axi_rdata   = rdata_v[0];
    assign s1_axi_rdata   = rdata_v[1];
    assign s0_axi_rresp   = AXI_RESP_OKAY;
    assign s1_axi_rresp   = AXI_RESP_OKAY;

    assign bram_porta_clk  = aclk;
    assign bram_porta_rst  = areset;
    assign bram_porta_addr = addr_reg;

endmodule

// File: tb/tb_axi_bram_read_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axi_bram_read_arbiter
// Randomised and directed reads from both slaves against a BRAM model.
// A reference model (negedge monitor) predicts grants from the round-robin
// rule, queues the expected word for each accepted read and compares R data,
// rvalid timing (grant + 3), arready gating and rdata hold behaviour.
// -----------------------------------------------------------------------------
module tb_axi_bram_read_arbiter;

    logic        clk = 1'b0;
    logic        areset = 1'b1;
    logic [15:0] araddr [2];
    logic [1:0]  arvalid = 2'b00;
    logic [1:0]  arready;
    logic [31:0] rdata [2];
    logic [1:0]  rresp [2];
    logic [1:0]  rvalid;
    logic [1:0]  rready = 2'b00;
    logic        bram_clk;
    logic        bram_rst;
    logic [9:0]  bram_addr;
    logic [31:0] bram_rddata;

    always #5 clk = ~clk;

    axi_bram_read_arbiter dut (
        .aclk              (clk),
        .areset            (areset),
        .s0_axi_araddr     (araddr[0]),
        .s0_axi_arvalid    (arvalid[0]),
        .s0_axi_arready    (arready[0]),
        .s0_axi_rdata      (rdata[0]),
        .s0_axi_rresp      (rresp[0]),
        .s0_axi_rvalid     (rvalid[0]),
        .s0_axi_rready     (rready[0]),
        .s1_axi_araddr     (araddr[1]),
        .s1_axi_arvalid    (arvalid[1]),
        .s1_axi_arready    (arready[1]),
        .s1_axi_rdata      (rdata[1]),
        .s1_axi_rresp      (rresp[1]),
        .s1_axi_rvalid     (rvalid[1]),
        .s1_axi_rready     (rready[1]),
        .bram_porta_clk    (bram_clk),
        .bram_porta_rst    (bram_rst),
        .bram_porta_addr   (bram_addr),
        .bram_porta_rddata (bram_rddata)
    );

    // BRAM model: one-cycle registered read; bad_mode drives junk on the
    // data bus to show the arbiter does not rely on BRAM output hold.
    logic [31:0] mem [1024];
    logic [31:0] bram_q;
    logic        bad_mode = 1'b0;
    always @(posedge clk) bram_q <= mem[bram_addr];
    assign bram_rddata = bad_mode ? 32'hDEADBEEF : bram_q;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rr_mode = 2;   // 0 random rready, 1 held low, 2 held high

    typedef struct {
        int          port;
        logic [9:0]  word;
        logic [31:0] data;
        int          cyc;
    } exp_t;
    exp_t exp_q [$];

    // Reference model state
    bit          m_busy = 0;
    bit          m_last = 1;
    int          m_owner = 0;
    int          m_cnt = 0;
    logic [31:0] last_data [2];

    function automatic logic [9:0] word_of(input logic [15:0] a);
        return 10'((a >> 2) & 16'h03FF);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out (cycle %0d)", name, cyc);
    endtask

    // rready driver
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rr_mode)
                0:       rready = 2'($urandom_range(0, 3));
                1:       rready = 2'b00;
                default: rready = 2'b11;
            endcase
        end
    end

    // Monitor + reference model, sampled mid-cycle.
    initial begin
        logic [1:0] exp_g;
        logic [1:0] exp_rv;
        int         w;
        int         other;
        exp_t       e;
        last_data[0] = '0;
        last_data[1] = '0;
        forever begin
            @(negedge clk);
            if (areset) begin
                chk("arready_in_reset", arready, 0);
                m_busy = 0;
                m_last = 1;
                m_cnt  = 0;
                exp_q.delete();
                last_data[0] = '0;
                last_data[1] = '0;
            end else if (!m_busy) begin
                if (arvalid == 2'b11) exp_g = m_last ? 2'b01 : 2'b10;
                else                  exp_g = arvalid;
                chk("arready_grant", arready, exp_g);
                chk("rvalid_idle", rvalid, 0);
                chk("rdata0_hold", rdata[0], last_data[0]);
                chk("rdata1_hold", rdata[1], last_data[1]);
                chk("rresp", {rresp[1], rresp[0]}, 0);
                if (exp_g != 2'b00) begin
                    w      = exp_g[1] ? 1 : 0;
                    e.port = w;
                    e.word = word_of(araddr[w]);
                    e.data = mem[e.word];
                    e.cyc  = cyc;
                    exp_q.push_back(e);
                    m_busy  = 1;
                    m_owner = w;
                    m_last  = (w == 1);
                    m_cnt   = 0;
                end
            end else begin
                m_cnt++;
                other = 1 - m_owner;
                chk("arready_busy", arready, 0);
                exp_rv = (m_cnt >= 3) ? 2'(2'b01 << m_owner) : 2'b00;
                chk("rvalid", rvalid, exp_rv);
                chk("rresp", {rresp[1], rresp[0]}, 0);
                if (m_cnt == 1) chk("bram_addr", bram_addr, exp_q[0].word);
                chk("rdata_nonowner_hold", rdata[other], last_data[other]);
                if (m_cnt < 3) begin
                    chk("rdata_owner_hold", rdata[m_owner], last_data[m_owner]);
                end else begin
                    chk("rdata", rdata[m_owner], exp_q[0].data);
                    if (rready[m_owner]) begin
                        e = exp_q.pop_front();
                        last_data[m_owner] = e.data;
                        m_busy = 0;
                        $display("read s%0d word=%0d data=%h granted@%0d done@%0d",
                                 e.port, e.word, e.data, e.cyc, cyc);
                    end
                end
            end
            cyc++;
        end
    end

    // All stimulus tasks start and end at posedge+1.
    task automatic do_reset();
        areset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        areset = 1'b0;
    endtask

    task automatic ar_issue(input int p, input logic [15:0] a);
        bit hs = 0;
        araddr[p]  = a;
        arvalid[p] = 1'b1;
        for (int n = 0; n < 100 && !hs; n++) begin
            @(negedge clk);
            hs = arready[p];
            @(posedge clk);
            #1;
        end
        arvalid[p] = 1'b0;
        if (!hs) timeout_fail("ar_handshake");
    endtask

    // Keeps arvalid high across consecutive reads.
    task automatic ar_stream(input int p, input int count);
        int done = 0;
        araddr[p]  = 16'($urandom_range(0, 65535));
        arvalid[p] = 1'b1;
        for (int n = 0; n < 400 && done < count; n++) begin
            @(negedge clk);
            if (arready[p]) done++;
            @(posedge clk);
            #1;
            araddr[p] = 16'($urandom_range(0, 65535));
        end
        arvalid[p] = 1'b0;
        if (done < count) timeout_fail("ar_stream");
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        #2;
        while ((m_busy || exp_q.size() != 0) && n < 200) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (n >= 200) timeout_fail("wait_idle");
        @(posedge clk);
        #1;
    endtask

    task automatic random_port(input int p, input int count);
        for (int k = 0; k < count; k++) begin
            repeat ($urandom_range(0, 4)) @(posedge clk);
            #1;
            ar_issue(p, 16'($urandom_range(0, 65535)));
        end
    endtask

    initial begin
        bit seen;
        araddr[0] = '0;
        araddr[1] = '0;
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        areset = 1'b0;
        @(negedge clk);
        chk("reset_bram_addr", bram_addr, 0);
        chk("reset_rvalid", rvalid, 0);
        chk("reset_rdata0", rdata[0], 0);
        chk("reset_rdata1", rdata[1], 0);
        @(posedge clk);
        #1;

        // Single read from s0
        rr_mode = 2;
        ar_issue(0, 16'h0010);
        wait_idle();

        // Simultaneous requests right after reset: s0 wins first
        do_reset();
        fork
            ar_issue(0, 16'h0008);
            ar_issue(1, 16'h000C);
        join
        wait_idle();

        // Continuous requests from both: grants must alternate
        fork
            ar_stream(0, 3);
            ar_stream(1, 3);
        join
        wait_idle();

        // s1 stalls with rready low while BRAM output goes bad; s0 held off
        rr_mode = 1;
        ar_issue(1, 16'h0104);
        seen = 0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            seen = rvalid[1];
        end
        if (!seen) timeout_fail("wait_rvalid_s1");
        @(posedge clk);
        #1;
        fork
            ar_issue(0, 16'h0020);
            begin
                bad_mode = 1'b1;
                repeat (10) @(posedge clk);
                #1;
                bad_mode = 1'b0;
                rr_mode  = 2;
            end
        join
        wait_idle();

        // Reset while the read is in CAPT, then both request
        ar_issue(0, 16'h0030);   // returns in ADDR
        @(posedge clk);
        #1;                      // now in CAPT
        areset = 1'b1;
        @(posedge clk);
        #1;
        areset = 1'b0;
        fork
            ar_issue(0, 16'h0044);
            ar_issue(1, 16'h0048);
        join
        wait_idle();

        // Randomised traffic with random rready back-pressure
        rr_mode = 0;
        fork
            random_port(0, 15);
            random_port(1, 15);
        join
        rr_mode = 2;
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
